// File: rtl/cpu_ifetch_if.sv
// rtl/cpu_ifetch_if.sv - instruction bus and FIFO write-port bundle for cpu_ifetch
interface cpu_ifetch_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        fifo_full_i;
  logic        fifo_write_en_o;
  logic [31:0] fifo_data_o;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, fifo_write_en_o, fifo_data_o,
    input  wb_dat_i, wb_ack_i, fifo_full_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, fifo_write_en_o, fifo_data_o,
    output wb_dat_i, wb_ack_i, fifo_full_i
  );
endinterface

// File: rtl/cpu_ifetch.sv
// rtl/cpu_ifetch.sv - instruction fetch sequencer feeding the instruction FIFO
// Optional bus watchdog enabled by defining CPU_IFETCH_TIMEOUT_EN.
module cpu_ifetch #(
  parameter logic [31:0] BOOT_ADDRESS   = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_target_i,
  cpu_ifetch_if.master        bus,
  output logic                newPC_p_o,
  output logic [31:0]         PC_o,
  output logic                fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] carry_q, carry_d;
  logic        push_q, push_d;
  logic        newpc_q, newpc_d;
  logic        realign_q, realign_d;
  logic        carry_valid_q, carry_valid_d;
  logic        busy;
  logic        expired;
  logic        halt_q;

  assign busy = (state_q != IDLE);

`ifdef CPU_IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             halt_d;

  // A watchdog hit in the same cycle as a redirect yields to the redirect.
  assign expired = busy && !bus.wb_ack_i && !branch_i
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    fault_d = fault_q | expired;
    halt_d  = halt_q;
    if (busy && state_d == state_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (branch_i) begin
      halt_d = 1'b0;
    end else if (expired) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      halt_q  <= halt_d;
    end
  end

  assign fault_o = fault_q;
`else
  assign expired = 1'b0;
  assign halt_q  = 1'b0;
  assign fault_o = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
  end
`endif

  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    data_d        = data_q;
    pc_d          = pc_q;
    carry_d       = carry_q;
    push_d        = push_q;
    newpc_d       = 1'b0;
    realign_d     = realign_q;
    carry_valid_d = carry_valid_q;

    if (push_q && !stall_i) begin
      push_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!push_q && !bus.fifo_full_i && !halt_q) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.wb_ack_i) begin
          state_d = IDLE;
          adr_d   = adr_q + 32'd4;
          if (realign_q) begin
            // The first word after a halfword-aligned target only primes the carry.
            carry_d       = bus.wb_dat_i[15:0];
            carry_valid_d = 1'b1;
            if (carry_valid_q) begin
              push_d = 1'b1;
              data_d = {carry_q, bus.wb_dat_i[31:16]};
            end
          end else begin
            push_d = 1'b1;
            data_d = bus.wb_dat_i;
          end
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (bus.wb_ack_i || expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (branch_i) begin
      push_d        = 1'b0;
      carry_valid_d = 1'b0;
      adr_d         = {branch_target_i[31:2], 2'b00};
      realign_d     = branch_target_i[1];
      newpc_d       = 1'b1;
      pc_d          = branch_target_i;
      state_d       = (busy && !bus.wb_ack_i) ? DISCARD : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      adr_q         <= {BOOT_ADDRESS[31:2], 2'b00};
      data_q        <= '0;
      pc_q          <= BOOT_ADDRESS;
      carry_q       <= '0;
      push_q        <= 1'b0;
      newpc_q       <= 1'b1;
      realign_q     <= BOOT_ADDRESS[1];
      carry_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      adr_q         <= adr_d;
      data_q        <= data_d;
      pc_q          <= pc_d;
      carry_q       <= carry_d;
      push_q        <= push_d;
      newpc_q       <= newpc_d;
      realign_q     <= realign_d;
      carry_valid_q <= carry_valid_d;
    end
  end

  assign bus.wb_adr_o        = adr_q;
  assign bus.wb_cyc_o        = busy;
  assign bus.wb_stb_o        = busy;
  assign bus.wb_we_o         = 1'b0;
  assign bus.fifo_write_en_o = push_q;
  assign bus.fifo_data_o     = data_q;
  assign newPC_p_o           = newpc_q;
  assign PC_o                = pc_q;

endmodule
